// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Execute-stage branch and flag resolver for the pipelined RAT CPU. It holds
//   the C, Z and I flags and the interrupt shadow copies of C and Z. It also
//   evaluates the branch class of the instruction in EX and drives the
//   redirect controls (UNCON_BRN / TAKE_COND_BRN / PC_SEL). After every
//   redirect, it suppresses the next SHADOW_CYCLES EX slots.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_ex_valid      EX slot holds a real instruction
//   i_br_type[2:0]  0 none, 1 BRN, 2 BREQ, 3 BRNE, 4 BRCS, 5 BRCC, 6 CALL, 7 RET
//   i_is_reti       qualifies br_type 7 as RETI
//   i_flg_c_ld      load C from i_c_in
//   i_flg_z_ld      load Z from i_z_in
//   i_c_in, i_z_in  ALU carry / zero results
//   i_flg_c_set     SEC
//   i_flg_c_clr     CLC
//   i_i_set         SEI
//   i_i_clr         CLI
//   i_intr          level-sensitive interrupt request
//   o_uncon_brn     unconditional redirect this cycle (combinational)
//   o_take_cond_brn taken conditional branch this cycle (combinational)
//   o_pc_sel[1:0]   0 PC+1, 1 IR target, 2 stack, 3 interrupt vector
//   o_int_taken     interrupt accepted this cycle
//   o_c_flag        registered carry flag
//   o_z_flag        registered zero flag
//   o_i_flag        registered interrupt-enable flag
//   o_squash        current EX slot is suppressed
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int SHADOW_CYCLES = 3,
    parameter int INT_VECTOR    = 10'h3FF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ex_valid,
    input  logic [2:0] i_br_type,
    input  logic       i_is_reti,
    input  logic       i_flg_c_ld,
    input  logic       i_flg_z_ld,
    input  logic       i_c_in,
    input  logic       i_z_in,
    input  logic       i_flg_c_set,
    input  logic       i_flg_c_clr,
    input  logic       i_i_set,
    input  logic       i_i_clr,
    input  logic       i_intr,
    output logic       o_uncon_brn,
    output logic       o_take_cond_brn,
    output logic [1:0] o_pc_sel,
    output logic       o_int_taken,
    output logic       o_c_flag,
    output logic       o_z_flag,
    output logic       o_i_flag,
    output logic       o_squash
);

    localparam int CW = $clog2(SHADOW_CYCLES + 1);

    // The vector address is consumed by the fetch stage. Here it is only
    // checked so that it fits the 10-bit program counter.
    if (SHADOW_CYCLES < 1 || INT_VECTOR < 0 || INT_VECTOR > 10'h3FF) begin : g_bad_param
        $error("branch_resolve_unit: illegal SHADOW_CYCLES or INT_VECTOR");
    end

    logic [CW-1:0] r_shadow_cnt;
    logic          r_c, r_z, r_i;
    logic          r_shad_c, r_shad_z;

    logic w_squash, w_act, w_is_branch, w_reti;
    logic w_uncon, w_cond, w_int_taken;
    logic w_c_next, w_z_next, w_i_next;

    // Reset is folded into the activity qualifier. Every combinational output
    // therefore reads 0 while reset is held, whatever the EX inputs are.
    assign w_squash    = (r_shadow_cnt != '0);
    assign w_act       = i_ex_valid & ~w_squash & ~i_rst;
    assign w_is_branch = w_act & (i_br_type != 3'd0);
    assign w_reti      = w_act & (i_br_type == 3'd7) & i_is_reti;

    // A branch in EX wins over the interrupt. The request stays pending for
    // as long as INTR is held.
    assign w_int_taken = r_i & i_intr & ~w_squash & ~w_is_branch & ~i_rst;

    assign w_uncon = (w_act & ((i_br_type == 3'd1) | (i_br_type == 3'd6) |
                               (i_br_type == 3'd7))) | w_int_taken;

    // Conditions read the registered flags only, so a flag written in the
    // same cycle is not seen by this branch.
    always_comb begin
        w_cond = 1'b0;
        if (w_act) begin
            case (i_br_type)
                3'd2:    w_cond = r_z;
                3'd3:    w_cond = ~r_z;
                3'd4:    w_cond = r_c;
                3'd5:    w_cond = ~r_c;
                default: w_cond = 1'b0;
            endcase
        end
    end

    always_comb begin
        o_pc_sel = 2'd0;
        if (w_int_taken)
            o_pc_sel = 2'd3;
        else if (w_act && i_br_type == 3'd7)
            o_pc_sel = 2'd2;
        else if (w_uncon || w_cond)
            o_pc_sel = 2'd1;
    end

    // Normal flag next-state. SET beats CLR, and CLR beats LD. RETI and
    // interrupt acceptance are layered on top in the register block.
    always_comb begin
        w_c_next = r_c;
        w_z_next = r_z;
        w_i_next = r_i;
        if (w_act) begin
            if (i_flg_c_set)
                w_c_next = 1'b1;
            else if (i_flg_c_clr)
                w_c_next = 1'b0;
            else if (i_flg_c_ld)
                w_c_next = i_c_in;
            if (i_flg_z_ld)
                w_z_next = i_z_in;
            if (i_i_set)
                w_i_next = 1'b1;
            else if (i_i_clr)
                w_i_next = 1'b0;
        end
    end

    // Flag registers. RETI restores the shadow copies and re-enables
    // interrupts, and it discards any other flag write in that cycle.
    // Interrupt acceptance snapshots the post-write C/Z values and
    // disables interrupts. RETI is a branch, so it can never coincide
    // with an accepted interrupt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_i      <= 1'b0;
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else if (w_reti) begin
            r_c <= r_shad_c;
            r_z <= r_shad_z;
            r_i <= 1'b1;
        end else begin
            r_c <= w_c_next;
            r_z <= w_z_next;
            r_i <= w_int_taken ? 1'b0 : w_i_next;
            if (w_int_taken) begin
                r_shad_c <= w_c_next;
                r_shad_z <= w_z_next;
            end
        end
    end

    // Squash window. The counter reloads on every redirect, so it is nonzero
    // for exactly SHADOW_CYCLES slots after the redirect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_shadow_cnt <= '0;
        else if (w_uncon || w_cond)
            r_shadow_cnt <= CW'(SHADOW_CYCLES);
        else if (r_shadow_cnt != '0)
            r_shadow_cnt <= r_shadow_cnt - 1'b1;
    end

    assign o_uncon_brn     = w_uncon;
    assign o_take_cond_brn = w_cond;
    assign o_int_taken     = w_int_taken;
    assign o_c_flag        = r_c;
    assign o_z_flag        = r_z;
    assign o_i_flag        = r_i;
    assign o_squash        = w_squash;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch and flag resolver for the pipelined RAT CPU.
- Holds the C, Z and I flags plus the interrupt shadow flags, and evaluates the branch class of the instruction currently in EX.
- Drives UNCON_BRN and TAKE_COND_BRN into the NOP generator, and drives PC source select to the fetch stage.
- Suppresses its own decisions and flag writes for the squashed slots that follow a taken redirect.

Parameters:
- SHADOW_CYCLES, 3: number of EX slots after a redirect that are squashed. Must match the NOP generator's EX_NOP window.
- INT_VECTOR, 10'h3FF: PC target for an interrupt.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- EX_VALID  in  1  EX slot holds a real instruction
- BR_TYPE  in  3  0 none, 1 BRN, 2 BREQ, 3 BRNE, 4 BRCS, 5 BRCC, 6 CALL, 7 RET
- IS_RETI  in  1  qualifies BR_TYPE=7 as RETI
- FLG_C_LD  in  1  load C from C_IN
- FLG_Z_LD  in  1  load Z from Z_IN
- C_IN  in  1  ALU carry result
- Z_IN  in  1  ALU zero result
- FLG_C_SET  in  1  SEC
- FLG_C_CLR  in  1  CLC
- I_SET  in  1  SEI
- I_CLR  in  1  CLI
- INTR  in  1  level interrupt request
- UNCON_BRN  out  1  unconditional redirect this cycle (combinational)
- TAKE_COND_BRN  out  1  taken conditional branch this cycle (combinational)
- PC_SEL  out  2  0 PC+1, 1 IR target, 2 stack, 3 INT_VECTOR
- INT_TAKEN  out  1  interrupt accepted this cycle; pushes the PC
- C_FLAG  out  1  registered carry flag
- Z_FLAG  out  1  registered zero flag
- I_FLAG  out  1  registered interrupt-enable flag
- SQUASH  out  1  current EX slot is suppressed (SHADOW_CNT != 0)

Behaviour:
- Reset (async, RESET=1): C, Z, I, SHAD_C, SHAD_Z and SHADOW_CNT all clear to 0. While reset is held, every output is 0 and PC_SEL=0.
- act = EX_VALID & ~SQUASH. All decisions and flag writes are gated by act. A squashed slot has no architectural effect.
- UNCON_BRN = act & BR_TYPE in {1,6,7}, or INT_TAKEN.
- TAKE_COND_BRN = act & one of:
  - BR_TYPE=2 & Z
  - BR_TYPE=3 & ~Z
  - BR_TYPE=4 & C
  - BR_TYPE=5 & ~C
  - The two outputs are never both 1.
- Conditions use the registered flags only. A flag write in cycle n is visible to a branch in cycle n+1. There is no same-cycle bypass.
- INT_TAKEN = I & INTR & ~SQUASH & ~(act & BR_TYPE!=0).
  - A branch in EX has priority; the interrupt stays pending while INTR is held.
  - A non-branch instruction in EX completes normally alongside the interrupt.
- PC_SEL priority:
  - 3 if INT_TAKEN
  - else 2 if act & BR_TYPE=7
  - else 1 if UNCON_BRN or TAKE_COND_BRN
  - else 0
- SHADOW_CNT (width clog2(SHADOW_CYCLES+1)):
  - Loads SHADOW_CYCLES when UNCON_BRN or TAKE_COND_BRN is 1.
  - Otherwise decrements when nonzero and holds at 0.
  - The counter is nonzero during exactly SHADOW_CYCLES cycles after a redirect.
- Flag next-state, applied only when act:
  - C: FLG_C_SET -> 1, else FLG_C_CLR -> 0, else FLG_C_LD -> C_IN. SET wins over CLR over LD.
  - Z: FLG_Z_LD -> Z_IN.
  - I: I_SET -> 1, else I_CLR -> 0.
- INT_TAKEN:
  - SHAD_C/SHAD_Z capture the next-state C/Z, including this cycle's write.
  - I <= 0. This overrides any I_SET in the same cycle.
- RETI (act & BR_TYPE=7 & IS_RETI): C <= SHAD_C, Z <= SHAD_Z, I <= 1. Any other flag write in the same cycle is ignored.
- Reset asserted mid-shadow clears SHADOW_CNT; the first valid slot after release is live.
- INTR is level-sensitive and is not latched. Deasserting INTR before acceptance drops the request.

Test Plan:
- Reset mid-operation: RESET pulsed asynchronously between clock edges while SHADOW_CNT=2 and C=1 -> all flags and the counter are 0 immediately; SQUASH=0 on the first cycle after release.
- Conditional branch: cycle 0 with FLG_Z_LD=1, Z_IN=1; cycle 1 with BR_TYPE=2 -> TAKE_COND_BRN=1 and PC_SEL=1 in cycle 1; SQUASH=1 in cycles 2-4; a BRN presented in cycle 3 gives UNCON_BRN=0 and its flag writes are dropped.
- Branch not taken and unconditional branch: Z=0 with BR_TYPE=2 -> TAKE_COND_BRN=0, PC_SEL=0, SQUASH stays 0; BR_TYPE=6 -> UNCON_BRN=1, PC_SEL=1.
- Interrupt versus branch: I=1, INTR=1 together with BR_TYPE=1 -> UNCON_BRN=1, INT_TAKEN=0. With INTR held, the first unsquashed non-branch cycle (cycle 4) gives INT_TAKEN=1, PC_SEL=3, I=0 next cycle.
- Shadow capture with same-cycle write: C=1, Z=0; interrupt taken in the same cycle as FLG_Z_LD=1, Z_IN=1 -> SHAD_Z=1, SHAD_C=1. After CLC, a later RETI restores C=1, Z=1, I=1 and gives PC_SEL=2.
- C flag priority: FLG_C_SET and FLG_C_CLR both 1 with FLG_C_LD=1, C_IN=0 -> C=1 next cycle.
